clock_time_ctrl: RTL and testbench
==================================

// Module: clock_time_ctrl
// PURPOSE
//   Timekeeping and set-mode controller for the HH:MM LED clock. Keeps BCD time from the
//   board clock, runs a RUN/SET_HOUR/SET_MIN state machine driven by two push-buttons,
//   and drives the digit, per-digit blank and colon inputs of the display multiplexer.
// PARAMETERS
//   HALF_SEC_DIV  5_000_000  Clock cycles per half-second tick (10 MHz board clock); >= 2
// PORTS
//   Clock        in   1  board clock; all state on rising edge
//   Reset_n      in   1  asynchronous, active-low reset
//   btn_mode     in   1  mode button, active high, debounced, asynchronous to Clock
//   btn_inc      in   1  increment button, active high, debounced, asynchronous to Clock
//   hourten      out  4  BCD hours tens
//   hourone      out  4  BCD hours ones
//   mintens      out  4  BCD minutes tens
//   minones      out  4  BCD minutes ones
//   blank        out  4  per-digit blank, 1 = dark; [3]=hourten [2]=hourone [1]=mintens [0]=minones
//   colon        out  1  colon segment enable
//   pm           out  1  PM indicator (TWELVE_HOUR_EN only; else constant 0)
//   mode_state   out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
// BEHAVIOUR
//   Reset (async): time 00:00:00 (12:00:00 AM with macro), prescaler 0, phase 0, state RUN,
//     blank=0000, colon=1, pm=0, mode_state=00, button sync/edge flops 0.
//   Buttons: 2-flop sync + 1 delay flop per button; action on rising edge only. Press
//     acts 3 Clock edges after input rise. Held button = one action (no auto-repeat).
//   Prescaler: counts 0..HALF_SEC_DIV-1, emits 1-cycle half_tick at terminal count, wraps
//     to 0. phase toggles on every half_tick; phase 1->0 transition = sec_tick.
//     Prescaler and phase run in all states.
//   RUN: sec_tick advances seconds 0..59; 59->0 carries to minutes; 59->0 carries to
//     hours; 23:59:59 -> 00:00:00. BCD ones 9->0 carries tens; never emits codes >9.
//     colon = ~phase (1 Hz blink). blank=0000. btn_inc ignored.
//   FSM: mode edge RUN->SET_HOUR->SET_MIN->RUN. Entering SET_HOUR: seconds frozen.
//     Leaving SET_MIN->RUN: seconds, prescaler and phase cleared to 0 on that edge.
//   SET_HOUR: inc edge adds 1 hour, 23->00, no effect on minutes. blank=1100 while
//     phase=1 else 0000. colon=1. Time does not advance.
//   SET_MIN: inc edge adds 1 minute, 59->00, no carry into hours. blank=0011 while
//     phase=1 else 0000. colon=1. Time does not advance.
//   Simultaneous mode and inc edges in same cycle: mode wins, inc discarded.
//   Reset asserted mid-set: immediate return to reset values, set edits lost.
//   Outputs registered; digit change visible 1 cycle after the causing tick/edge.
// CONFIGURATION
//   TWELVE_HOUR_EN defined: hours range 1..12; reset 12:00 AM; RUN 12:59:59->01:00:00;
//     11:59:59->12:00:00 toggles pm; SET_HOUR inc 12->01, 11->12 toggles pm; hourten=0
//     forces blank[3]=1 (leading-zero suppression, ORed with set blink).
//   Not defined: 24-hour 00..23 as above; pm tied 0; no leading-zero suppression.
// TESTING  (HALF_SEC_DIV=4 in bench)
//   Reset release -> 00:00, mode_state=00, colon toggles every 4 cycles, blank=0000.
//   Preload 23:59:59 via set + 59 sec_ticks; next sec_tick -> 00:00, no codes >9 seen.
//   mode x1, inc x3 -> 03:00, minutes unchanged; blank=1100 only while phase=1.
//   mode x2 from RUN, inc x61 at 00:xx -> minutes wrap 59->00 with hours still 00.
//   mode and inc same cycle in RUN -> mode_state=01, hours unchanged.
//   TWELVE_HOUR_EN: 11:59:59 + sec_tick -> 12:00, pm=1; 12:59:59 -> 01:00, blank[3]=1.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM timekeeping plus RUN/SET_HOUR/SET_MIN controller for
// the LED clock. Produces BCD digits, per-digit blanking and colon for the
// display multiplexer. Optional macro TWELVE_HOUR_EN selects a 12-hour clock
// with PM indicator and hour-tens leading-zero suppression.
module clock_time_ctrl #(
   parameter int unsigned HALF_SEC_DIV = 5_000_000
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hourten,
   output logic [3:0] hourone,
   output logic [3:0] mintens,
   output logic [3:0] minones,
   output logic [3:0] blank,
   output logic       colon,
   output logic       pm,
   output logic [1:0] mode_state
);

   localparam int unsigned PW = (HALF_SEC_DIV > 2) ? $clog2(HALF_SEC_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_SEC_DIV - 1);

`ifdef TWELVE_HOUR_EN
   localparam logic [7:0] HOUR_RST = 8'h12;
`else
   localparam logic [7:0] HOUR_RST = 8'h00;
`endif

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          phase_q, phase_d;
   logic [5:0]    sec_q, sec_d;
   logic [7:0]    hour_q, hour_d;
   logic [7:0]    min_q, min_d;
   logic          pm_q, pm_d;
   logic [3:0]    blank_q, blank_d;
   logic          colon_q, colon_d;

   logic mode_s1_q, mode_s2_q, mode_dly_q;
   logic inc_s1_q, inc_s2_q, inc_dly_q;
   logic mode_edge, inc_edge, half_tick, sec_tick;

   // BCD hour increment with range wrap
   function automatic logic [7:0] hour_inc(input logic [7:0] h);
`ifdef TWELVE_HOUR_EN
      if (h == 8'h12)
         return 8'h01;
`else
      if (h == 8'h23)
         return 8'h00;
`endif
      else if (h[3:0] == 4'd9)
         return {h[7:4] + 4'd1, 4'd0};
      else
         return {h[7:4], h[3:0] + 4'd1};
   endfunction

   // BCD minute increment, 59 wraps to 00
   function automatic logic [7:0] min_inc(input logic [7:0] m);
      if (m == 8'h59)
         return 8'h00;
      else if (m[3:0] == 4'd9)
         return {m[7:4] + 4'd1, 4'd0};
      else
         return {m[7:4], m[3:0] + 4'd1};
   endfunction

   assign mode_edge = mode_s2_q & ~mode_dly_q;
   assign inc_edge  = inc_s2_q & ~inc_dly_q;
   assign half_tick = (presc_q == PRESC_LAST);
   assign sec_tick  = half_tick & phase_q;

   // Button synchronisers and rising-edge delay flops
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         mode_s1_q  <= 1'b0;
         mode_s2_q  <= 1'b0;
         mode_dly_q <= 1'b0;
         inc_s1_q   <= 1'b0;
         inc_s2_q   <= 1'b0;
         inc_dly_q  <= 1'b0;
      end else begin
         mode_s1_q  <= btn_mode;
         mode_s2_q  <= mode_s1_q;
         mode_dly_q <= mode_s2_q;
         inc_s1_q   <= btn_inc;
         inc_s2_q   <= inc_s1_q;
         inc_dly_q  <= inc_s2_q;
      end
   end

   // Mode sequencing on mode-button edges
   always_comb begin
      state_d = state_q;
      if (mode_edge) begin
         case (state_q)
            RUN:      state_d = SET_HOUR;
            SET_HOUR: state_d = SET_MIN;
            default:  state_d = RUN;
         endcase
      end
   end

   // Timebase, time advance and set-mode edits
   always_comb begin
      presc_d = half_tick ? '0 : presc_q + PW'(1);
      phase_d = phase_q ^ half_tick;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      pm_d    = pm_q;
      case (state_q)
         RUN: begin
            if (sec_tick) begin
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 8'h59) begin
                     min_d  = 8'h00;
                     hour_d = hour_inc(hour_q);
`ifdef TWELVE_HOUR_EN
                     if (hour_q == 8'h11) pm_d = ~pm_q;
`endif
                  end else begin
                     min_d = min_inc(min_q);
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
         end
         SET_HOUR: begin
            if (inc_edge && !mode_edge) begin
               hour_d = hour_inc(hour_q);
`ifdef TWELVE_HOUR_EN
               if (hour_q == 8'h11) pm_d = ~pm_q;
`endif
            end
         end
         SET_MIN: begin
            if (mode_edge) begin
               // returning to RUN restarts the second from zero
               sec_d   = '0;
               presc_d = '0;
               phase_d = 1'b0;
            end else if (inc_edge) begin
               min_d = min_inc(min_q);
            end
         end
         default: ;
      endcase
   end

   // Display controls derived from next state so they align with the digits
   always_comb begin
      colon_d = 1'b1;
      blank_d = '0;
      case (state_d)
         RUN:      colon_d = ~phase_d;
         SET_HOUR: if (phase_d) blank_d = 4'b1100;
         SET_MIN:  if (phase_d) blank_d = 4'b0011;
         default:  ;
      endcase
`ifdef TWELVE_HOUR_EN
      if (hour_d[7:4] == 4'd0) blank_d[3] = 1'b1;
`endif
   end

   // State, time and display registers
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= RUN;
         presc_q <= '0;
         phase_q <= 1'b0;
         sec_q   <= '0;
         min_q   <= 8'h00;
         hour_q  <= HOUR_RST;
         pm_q    <= 1'b0;
         blank_q <= '0;
         colon_q <= 1'b1;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         pm_q    <= pm_d;
         blank_q <= blank_d;
         colon_q <= colon_d;
      end
   end

   assign hourten    = hour_q[7:4];
   assign hourone    = hour_q[3:0];
   assign mintens    = min_q[7:4];
   assign minones    = min_q[3:0];
   assign blank      = blank_q;
   assign colon      = colon_q;
   assign pm         = pm_q;
   assign mode_state = state_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with HALF_SEC_DIV=4 (sec_tick every 8 cycles).
// Build with TWELVE_HOUR_EN defined to exercise the 12-hour variant.
module tb_clock_time_ctrl;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] hourten, hourone, mintens, minones, blank;
   logic       colon, pm;
   logic [1:0] mode_state;

   int unsigned tests_run = 0;
   int unsigned errors = 0;
   logic        bad_code = 1'b0;

   clock_time_ctrl #(.HALF_SEC_DIV(4)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hourten(hourten), .hourone(hourone), .mintens(mintens), .minones(minones),
      .blank(blank), .colon(colon), .pm(pm), .mode_state(mode_state)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock)
      if (hourten > 4'd9 || hourone > 4'd9 || mintens > 4'd5 || minones > 4'd9)
         bad_code = 1'b1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] hhmm();
      return {hourten, hourone, mintens, minones};
   endfunction

   // Pulse buttons for 3 cycles (action lands on the 3rd edge), then settle 3 cycles
   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      repeat (3) @(negedge Clock);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (3) @(negedge Clock);
   endtask

   task automatic press_n(input logic m, input int n);
      for (int k = 0; k < n; k++) press(m, !m);
   endtask

   // Set hours/minutes by press counts and return to RUN (seconds cleared)
   task automatic preload(input int nh, input int nm);
      press(1'b1, 1'b0);
      press_n(1'b0, nh);
      press(1'b1, 1'b0);
      press_n(1'b0, nm);
      press(1'b1, 1'b0);
   endtask

   // After preload: 59 sec_ticks land at 8k cycles after the RUN-entry edge, 60th rolls the minute
   task automatic rollover(input string tag, input logic [15:0] pre, input logic [15:0] post);
      repeat (476) @(negedge Clock);
      check({tag, "_pre"}, hhmm(), pre);
      @(negedge Clock);
      check({tag, "_post"}, hhmm(), post);
   endtask

   // Over 8 cycles the blink pattern must be shown for exactly one half-second
   task automatic blink(input string tag, input logic [3:0] pat);
      int on = 0, off = 0, col = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clock);
         if (blank == pat) on++;
         if (blank == 4'b0000) off++;
         if (colon) col++;
      end
      check({tag, "_on"}, on, 4);
      check({tag, "_off"}, off, 4);
      check({tag, "_colon"}, col, 8);
   endtask

   initial begin
      repeat (2) @(negedge Clock);
`ifdef TWELVE_HOUR_EN
      check("rst_time", hhmm(), 16'h1200);
`else
      check("rst_time", hhmm(), 16'h0000);
`endif
      check("rst_mode", mode_state, 2'b00);
      check("rst_blank", blank, 4'b0000);
      check("rst_colon", colon, 1'b1);
      check("rst_pm", pm, 1'b0);
      Reset_n = 1'b1;

      for (int k = 1; k <= 12; k++) begin
         @(negedge Clock);
         if (k == 3 || k == 4 || k == 7 || k == 8 || k == 12)
            check("colon_blink", colon, ((k / 4) % 2) == 0);
      end
      check("run_blank", blank, 4'b0000);

`ifdef TWELVE_HOUR_EN
      preload(11, 59);
      rollover("roll_11", 16'h1159, 16'h1200);
      check("pm_set", pm, 1'b1);
      check("blank_12", blank[3], 1'b0);
      preload(0, 59);
      rollover("roll_12", 16'h1259, 16'h0100);
      check("blank_lz", blank[3], 1'b1);
      check("pm_hold", pm, 1'b1);
`else
      preload(23, 59);
      rollover("roll_23", 16'h2359, 16'h0000);

      press(1'b1, 1'b0);
      check("mode_sethour", mode_state, 2'b01);
      press_n(1'b0, 3);
      check("set_hour3", hhmm(), 16'h0300);
      blink("blink_hour", 4'b1100);

      press(1'b1, 1'b0);
      check("mode_setmin", mode_state, 2'b10);
      press_n(1'b0, 59);
      check("set_min59", hhmm(), 16'h0359);
      press(1'b0, 1'b1);
      check("min_wrap", hhmm(), 16'h0300);
      press(1'b0, 1'b1);
      check("min_after_wrap", hhmm(), 16'h0301);
      blink("blink_min", 4'b0011);

      press(1'b1, 1'b0);
      check("mode_run", mode_state, 2'b00);
      check("run_blank2", blank, 4'b0000);
      press(1'b0, 1'b1);
      check("run_inc_ignored", hhmm(), 16'h0301);

      press(1'b1, 1'b1);
      check("simul_mode", mode_state, 2'b01);
      check("simul_hours", hhmm(), 16'h0301);

      btn_inc = 1'b1;
      repeat (20) @(negedge Clock);
      btn_inc = 1'b0;
      repeat (3) @(negedge Clock);
      check("held_inc", hhmm(), 16'h0401);
      press(1'b0, 1'b1);
      check("inc_again", hhmm(), 16'h0501);

      #2 Reset_n = 1'b0;
      #1;
      check("midset_rst_time", hhmm(), 16'h0000);
      check("midset_rst_mode", mode_state, 2'b00);
      check("midset_rst_disp", {blank, colon}, 5'b00001);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
`endif
      check("bcd_range", bad_code, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests_run, errors);
      $finish;
   end

endmodule
